// File: rtl/lcd_fmt_pkg.sv
// rtl/lcd_fmt_pkg.sv - shared FSM states, ASCII constants and clamp limits for the LCD formatter
package lcd_fmt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_STORE,
    ST_COMMIT
  } state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam logic [2:0] FIELD_AZ  = 3'd0;
  localparam logic [2:0] FIELD_EL  = 3'd1;
  localparam logic [2:0] FIELD_HR  = 3'd2;
  localparam logic [2:0] FIELD_MIN = 3'd3;
  localparam logic [2:0] FIELD_SEC = 3'd4;

  localparam logic [4:0] HOURS_MAX   = 5'd23;
  localparam logic [5:0] MIN_SEC_MAX = 6'd59;

  localparam int SHIFT_CYCLES = 9;

  function automatic logic [7:0] to_ascii(input logic [3:0] digit);
    return ASCII_ZERO + {4'h0, digit};
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// rtl/bin2bcd_serial.sv - 9-bit serial double-dabble core, one bit per shift cycle
module bin2bcd_serial (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       shift,
  input  logic [8:0] din,
  output logic [3:0] bcd_h,
  output logic [3:0] bcd_t,
  output logic [3:0] bcd_u
);

  logic [8:0]  bin_q;
  logic [11:0] bcd_q;
  logic [11:0] bcd_adj;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  always_comb begin
    bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bin_q <= '0;
      bcd_q <= '0;
    end else if (load) begin
      bin_q <= din;
      bcd_q <= '0;
    end else if (shift) begin
      {bcd_q, bin_q} <= {bcd_adj[10:0], bin_q, 1'b0};
    end
  end

  assign bcd_h = bcd_q[11:8];
  assign bcd_t = bcd_q[7:4];
  assign bcd_u = bcd_q[3:0];

endmodule

// File: rtl/lcd_ascii_formatter.sv
// rtl/lcd_ascii_formatter.sv - snapshot, clamp and convert az/el/time/zone to ASCII digits
// Optional LEAD_ZERO_BLANK_EN: blank leading azimuth zeros with spaces.
module lcd_ascii_formatter
  import lcd_fmt_pkg::*;
#(
  parameter int AZ_MAX = 359,
  parameter int EL_MAX = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] azimuth,
  input  logic [6:0] elevation,
  input  logic [4:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic [2:0] zone_id,
  output logic       busy,
  output logic       done,
  output logic [7:0] az_h,
  output logic [7:0] az_t,
  output logic [7:0] az_u,
  output logic [7:0] el_t,
  output logic [7:0] el_u,
  output logic [7:0] t_h1,
  output logic [7:0] t_h0,
  output logic [7:0] t_m1,
  output logic [7:0] t_m0,
  output logic [7:0] t_s1,
  output logic [7:0] t_s0,
  output logic [7:0] zone_id_ascii
);

  localparam logic [8:0] AZ_LIM     = AZ_MAX[8:0];
  localparam logic [6:0] EL_LIM     = EL_MAX[6:0];
  localparam logic [3:0] SHIFT_LAST = 4'(SHIFT_CYCLES - 1);

  state_t      state;
  logic [2:0]  field_idx;
  logic [3:0]  shift_cnt;
  logic [8:0]  az_s;
  logic [6:0]  el_s;
  logic [4:0]  hr_s;
  logic [5:0]  min_s, sec_s;
  logic [2:0]  zone_s;
  logic [11:0] sh_az;
  logic [7:0]  sh_el, sh_hr, sh_min, sh_sec;
  logic [8:0]  din;
  logic [3:0]  bcd_h, bcd_t, bcd_u;

  // Clamping happens on the way into the converter so the snapshot keeps raw inputs.
  always_comb begin
    din = '0;
    case (field_idx)
      FIELD_AZ:  din = (az_s > AZ_LIM) ? AZ_LIM : az_s;
      FIELD_EL:  din = {2'b00, (el_s > EL_LIM) ? EL_LIM : el_s};
      FIELD_HR:  din = {4'h0, (hr_s > HOURS_MAX) ? HOURS_MAX : hr_s};
      FIELD_MIN: din = {3'b000, (min_s > MIN_SEC_MAX) ? MIN_SEC_MAX : min_s};
      FIELD_SEC: din = {3'b000, (sec_s > MIN_SEC_MAX) ? MIN_SEC_MAX : sec_s};
      default:   din = '0;
    endcase
  end

  bin2bcd_serial u_bcd (
    .clk   (clk),
    .reset (reset),
    .load  (state == ST_LOAD),
    .shift (state == ST_SHIFT),
    .din   (din),
    .bcd_h (bcd_h),
    .bcd_t (bcd_t),
    .bcd_u (bcd_u)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      field_idx     <= FIELD_AZ;
      shift_cnt     <= '0;
      az_s          <= '0;
      el_s          <= '0;
      hr_s          <= '0;
      min_s         <= '0;
      sec_s         <= '0;
      zone_s        <= '0;
      sh_az         <= '0;
      sh_el         <= '0;
      sh_hr         <= '0;
      sh_min        <= '0;
      sh_sec        <= '0;
      az_h          <= ASCII_ZERO;
      az_t          <= ASCII_ZERO;
      az_u          <= ASCII_ZERO;
      el_t          <= ASCII_ZERO;
      el_u          <= ASCII_ZERO;
      t_h1          <= ASCII_ZERO;
      t_h0          <= ASCII_ZERO;
      t_m1          <= ASCII_ZERO;
      t_m0          <= ASCII_ZERO;
      t_s1          <= ASCII_ZERO;
      t_s0          <= ASCII_ZERO;
      zone_id_ascii <= ASCII_ZERO;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            az_s      <= azimuth;
            el_s      <= elevation;
            hr_s      <= hours;
            min_s     <= minutes;
            sec_s     <= seconds;
            zone_s    <= zone_id;
            field_idx <= FIELD_AZ;
            busy      <= 1'b1;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          shift_cnt <= '0;
          state     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          shift_cnt <= shift_cnt + 4'd1;
          if (shift_cnt == SHIFT_LAST) state <= ST_STORE;
        end
        ST_STORE: begin
          case (field_idx)
            FIELD_AZ:  sh_az  <= {bcd_h, bcd_t, bcd_u};
            FIELD_EL:  sh_el  <= {bcd_t, bcd_u};
            FIELD_HR:  sh_hr  <= {bcd_t, bcd_u};
            FIELD_MIN: sh_min <= {bcd_t, bcd_u};
            default:   sh_sec <= {bcd_t, bcd_u};
          endcase
          if (field_idx == FIELD_SEC) begin
            state <= ST_COMMIT;
          end else begin
            field_idx <= field_idx + 3'd1;
            state     <= ST_LOAD;
          end
        end
        ST_COMMIT: begin
`ifdef LEAD_ZERO_BLANK_EN
          az_h <= (sh_az[11:8] == 4'h0) ? ASCII_SPACE : to_ascii(sh_az[11:8]);
          az_t <= (sh_az[11:4] == 8'h00) ? ASCII_SPACE : to_ascii(sh_az[7:4]);
`else
          az_h <= to_ascii(sh_az[11:8]);
          az_t <= to_ascii(sh_az[7:4]);
`endif
          az_u          <= to_ascii(sh_az[3:0]);
          el_t          <= to_ascii(sh_el[7:4]);
          el_u          <= to_ascii(sh_el[3:0]);
          t_h1          <= to_ascii(sh_hr[7:4]);
          t_h0          <= to_ascii(sh_hr[3:0]);
          t_m1          <= to_ascii(sh_min[7:4]);
          t_m0          <= to_ascii(sh_min[3:0]);
          t_s1          <= to_ascii(sh_sec[7:4]);
          t_s0          <= to_ascii(sh_sec[3:0]);
          zone_id_ascii <= ASCII_ZERO + {5'b00000, zone_s};
          done          <= 1'b1;
          busy          <= 1'b0;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_ascii_formatter.sv
// tb/tb_lcd_ascii_formatter.sv - directed self-checking bench for lcd_ascii_formatter
module tb_lcd_ascii_formatter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [8:0] azimuth = '0;
  logic [6:0] elevation = '0;
  logic [4:0] hours = '0;
  logic [5:0] minutes = '0;
  logic [5:0] seconds = '0;
  logic [2:0] zone_id = '0;
  logic       busy, done;
  logic [7:0] az_h, az_t, az_u, el_t, el_u;
  logic [7:0] t_h1, t_h0, t_m1, t_m0, t_s1, t_s0, zone_id_ascii;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcd_ascii_formatter dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .azimuth       (azimuth),
    .elevation     (elevation),
    .hours         (hours),
    .minutes       (minutes),
    .seconds       (seconds),
    .zone_id       (zone_id),
    .busy          (busy),
    .done          (done),
    .az_h          (az_h),
    .az_t          (az_t),
    .az_u          (az_u),
    .el_t          (el_t),
    .el_u          (el_u),
    .t_h1          (t_h1),
    .t_h0          (t_h0),
    .t_m1          (t_m1),
    .t_m0          (t_m0),
    .t_s1          (t_s1),
    .t_s0          (t_s0),
    .zone_id_ascii (zone_id_ascii)
  );

  wire [23:0] az_str   = {az_h, az_t, az_u};
  wire [15:0] el_str   = {el_t, el_u};
  wire [47:0] time_str = {t_h1, t_h0, t_m1, t_m0, t_s1, t_s0};
  wire [95:0] all_str  = {az_str, el_str, time_str, zone_id_ascii};

  // Drives inputs and start for the single sampling edge (E0); returns #1 after E0.
  task automatic pulse_start(input logic [8:0] az, input logic [6:0] el, input logic [4:0] h,
                             input logic [5:0] m, input logic [5:0] s, input logic [2:0] z);
    azimuth = az; elevation = el; hours = h; minutes = m; seconds = s; zone_id = z;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Cycles from E0 until done is seen; -1 when the budget runs out.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (all_str !== {12{8'h30}}) begin errors++; $display("FAIL reset_outputs got %h want all 30", all_str); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int n;
    pulse_start(9'd287, 7'd45, 5'd13, 6'd5, 6'd9, 3'd3);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_rise got %b want 1", busy); end
    wait_done(n);
    checks++; if (n != 56) begin errors++; $display("FAIL basic_latency got %0d want 56", n); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall got %b want 0", busy); end
    checks++; if (az_str !== "287") begin errors++; $display("FAIL basic_az got %h want %h", az_str, "287"); end
    checks++; if (el_str !== "45") begin errors++; $display("FAIL basic_el got %h want %h", el_str, "45"); end
    checks++; if (time_str !== "130509") begin errors++; $display("FAIL basic_time got %h want %h", time_str, "130509"); end
    checks++; if (zone_id_ascii !== "3") begin errors++; $display("FAIL basic_zone got %h want 33", zone_id_ascii); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
  endtask

  task automatic test_clamp;
    int n;
    pulse_start(9'd400, 7'd127, 5'd31, 6'd63, 6'd60, 3'd7);
    wait_done(n);
    checks++; if (n != 56) begin errors++; $display("FAIL clamp_latency got %0d want 56", n); end
    checks++; if (az_str !== "359") begin errors++; $display("FAIL clamp_az got %h want %h", az_str, "359"); end
    checks++; if (el_str !== "90") begin errors++; $display("FAIL clamp_el got %h want %h", el_str, "90"); end
    checks++; if (time_str !== "235959") begin errors++; $display("FAIL clamp_time got %h want %h", time_str, "235959"); end
    checks++; if (zone_id_ascii !== "7") begin errors++; $display("FAIL clamp_zone got %h want 37", zone_id_ascii); end
  endtask

  task automatic test_busy_start;
    int first_done = -1;
    int done_cnt = 0;
    pulse_start(9'd123, 7'd12, 5'd8, 6'd30, 6'd45, 3'd1);
    for (int i = 1; i <= 80; i++) begin
      if (i == 20) begin
        azimuth = 9'd99; elevation = 7'd3; hours = 5'd2; minutes = 6'd4; seconds = 6'd6; zone_id = 3'd6;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = i;
      end
    end
    start = 1'b0;
    checks++; if (first_done != 56) begin errors++; $display("FAIL busy_start_latency got %0d want 56", first_done); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL busy_start_done_count got %0d want 1", done_cnt); end
    checks++; if ({az_str, el_str, time_str, zone_id_ascii} !== {"123", "12", "083045", "1"}) begin
      errors++; $display("FAIL busy_start_result got %h want %h", all_str, {"123", "12", "083045", "1"});
    end
  endtask

  task automatic test_mid_reset;
    int n;
    int done_cnt = 0;
    pulse_start(9'd250, 7'd60, 5'd20, 6'd10, 6'd11, 3'd2);
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (all_str !== {12{8'h30}}) begin errors++; $display("FAIL midreset_outputs got %h want all 30", all_str); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
    reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) done_cnt++;
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL midreset_activity got %0d want 0", done_cnt); end
    pulse_start(9'd42, 7'd9, 5'd1, 6'd2, 6'd3, 3'd5);
    wait_done(n);
    checks++; if (n != 56) begin errors++; $display("FAIL midreset_latency got %0d want 56", n); end
`ifdef LEAD_ZERO_BLANK_EN
    checks++; if (az_str !== " 42") begin errors++; $display("FAIL midreset_az got %h want %h", az_str, " 42"); end
`else
    checks++; if (az_str !== "042") begin errors++; $display("FAIL midreset_az got %h want %h", az_str, "042"); end
`endif
    checks++; if ({el_str, time_str, zone_id_ascii} !== {"09", "010203", "5"}) begin
      errors++; $display("FAIL midreset_rest got %h want %h", {el_str, time_str, zone_id_ascii}, {"09", "010203", "5"});
    end
  endtask

  task automatic test_blank;
    int n;
    pulse_start(9'd7, 7'd5, 5'd0, 6'd0, 6'd0, 3'd0);
    wait_done(n);
    checks++; if (n != 56) begin errors++; $display("FAIL blank_latency got %0d want 56", n); end
`ifdef LEAD_ZERO_BLANK_EN
    checks++; if (az_str !== "  7") begin errors++; $display("FAIL blank_az got %h want %h", az_str, "  7"); end
`else
    checks++; if (az_str !== "007") begin errors++; $display("FAIL blank_az got %h want %h", az_str, "007"); end
`endif
    checks++; if ({el_str, time_str, zone_id_ascii} !== {"05", "000000", "0"}) begin
      errors++; $display("FAIL blank_rest got %h want %h", {el_str, time_str, zone_id_ascii}, {"05", "000000", "0"});
    end
  endtask

  task automatic test_back_to_back;
    int done_at[$];
    int glitches = 0;
    logic [95:0] held;
    logic [95:0] zero_img;
`ifdef LEAD_ZERO_BLANK_EN
    zero_img = {"  0", "00", "000000", "0"};
`else
    zero_img = {"000", "00", "000000", "0"};
`endif
    azimuth = '0; elevation = '0; hours = '0; minutes = '0; seconds = '0; zone_id = '0;
    held = all_str;
    start = 1'b1;
    for (int i = 1; i <= 180; i++) begin
      @(posedge clk); #1;
      if (done) begin
        done_at.push_back(i);
        held = all_str;
      end else if (all_str !== held) begin
        glitches++;
      end
    end
    start = 1'b0;
    checks++; if (done_at.size() != 3) begin errors++; $display("FAIL b2b_done_count got %0d want 3", done_at.size()); end
    if (done_at.size() == 3) begin
      checks++; if (done_at[0] != 57) begin errors++; $display("FAIL b2b_first got %0d want 57", done_at[0]); end
      checks++; if (done_at[1] - done_at[0] != 57) begin errors++; $display("FAIL b2b_gap1 got %0d want 57", done_at[1] - done_at[0]); end
      checks++; if (done_at[2] - done_at[1] != 57) begin errors++; $display("FAIL b2b_gap2 got %0d want 57", done_at[2] - done_at[1]); end
    end
    checks++; if (glitches != 0) begin errors++; $display("FAIL b2b_glitches got %0d want 0", glitches); end
    checks++; if (all_str !== zero_img) begin errors++; $display("FAIL b2b_outputs got %h want %h", all_str, zero_img); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_clamp;
    test_busy_start;
    test_mid_reset;
    test_blank;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
